// File: rtl/ifetch_axi_master_if.sv
// AXI4 read-channel bundle (AR + R) between the instruction fetch master and its slave.
interface ifetch_axi_master_if #(
  parameter int unsigned ID_WIDTH = 4
) ();
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ifetch_axi_master.sv
// Single-outstanding AXI4 instruction fetch master: one 32-bit beat per PC, delivered to the
// IF stage as a one-cycle accept pulse, with flush/stall handling that never leaks stale beats.
module ifetch_axi_master #(
  parameter int unsigned         ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] FETCH_ID = '0,
  parameter logic [31:0]         ERR_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                i_pc,
  input  logic                       i_flush,
  input  logic                       i_ex_stall,
  output logic [31:0]                o_inst,
  output logic                       o_rvalid_rready,
  output logic                       o_bus_err,
  ifetch_axi_master_if.master        axi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state_q;
  logic        drop_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] inst_q;
  logic        err_q;

  assign axi.arid    = FETCH_ID;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // Only one transaction is ever in flight, so RID and RLAST carry no information.
  logic unused_r;
  assign unused_r = ^{axi.rid, axi.rlast};

  assign o_inst          = inst_q;
  assign o_rvalid_rready = (state_q == HOLD) && !i_ex_stall && !i_flush;
  assign o_bus_err       = o_rvalid_rready && err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      araddr_q  <= 32'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      inst_q    <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A flush here means i_pc is about to change, so wait one cycle for the target.
          if (!i_flush) begin
            araddr_q  <= {i_pc[31:2], 2'b00};
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          // The request stays up through a flush; its beat is discarded later instead.
          if (i_flush) drop_q <= 1'b1;
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            if (drop_q || i_flush) begin
              drop_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              inst_q  <= (axi.rresp == 2'b00) ? axi.rdata : ERR_INST;
              err_q   <= (axi.rresp != 2'b00);
              state_q <= HOLD;
            end
          end else if (i_flush) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (i_flush || !i_ex_stall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ifetch_axi_master.md
Name: ifetch_axi_master

Overview:
- AXI4 read master that fetches one 32-bit instruction per transaction for the fetch stage.
- Sits directly upstream of the IF stage. It takes the current PC, issues a single-beat AR request, captures the R beat, and hands the instruction back with a one-cycle accept pulse.
- The IF stage advances its PC on that pulse.
- It handles flushes and EX stalls so that no stale or duplicate instruction ever reaches the pipeline.

Parameters:
- ID_WIDTH, 4, width of ARID/RID.
- FETCH_ID, 0, constant ARID driven on every request.
- ERR_INST, 32'h0000_0013, instruction word (NOP) returned when RRESP is not OKAY.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- i_pc  in  32  current fetch PC from the IF stage.
- i_flush  in  1  branch/jump redirect; the IF stage loads the new PC on this edge.
- i_ex_stall  in  1  pipeline stall; no instruction may be delivered while high.
- o_inst  out  32  fetched instruction.
- o_rvalid_rready  out  1  one-cycle pulse: o_inst valid and consumed this cycle.
- o_bus_err  out  1  one-cycle pulse alongside o_rvalid_rready when the beat had an error response.
- o_arid  out  ID_WIDTH  = FETCH_ID.
- o_araddr  out  32  {pc[31:2],2'b00}.
- o_arlen  out  8  = 0.
- o_arsize  out  3  = 3'b010.
- o_arburst  out  2  = 2'b01 (INCR).
- o_arvalid  out  1  address valid.
- i_arready  in  1  address ready.
- i_rid  in  ID_WIDTH  ignored (single outstanding).
- i_rdata  in  32  read data.
- i_rresp  in  2  read response.
- i_rlast  in  1  ignored (always a single beat).
- i_rvalid  in  1  read valid.
- o_rready  out  1  read ready.

Behaviour:
- Reset (rst=0, async): state=IDLE, drop=0, o_arvalid=0, o_araddr=0, o_rready=0, o_inst=0, o_rvalid_rready=0, o_bus_err=0, buffer empty. Releasing reset mid-transaction simply abandons it; the bench resets the slave at the same time.
- States: IDLE, ADDR, DATA, HOLD. At most one transaction is outstanding.
- IDLE:
  - If !i_flush: register o_araddr={i_pc[31:2],2'b00}, set o_arvalid=1, go to ADDR.
  - If i_flush: stay in IDLE, because the PC changes on this edge.
- ADDR:
  - o_arvalid and o_araddr are held stable until i_arready (AXI rule); a flush never withdraws the request.
  - On i_arready: o_arvalid=0, o_rready=1, go to DATA.
  - Flush in ADDR sets drop=1.
- DATA:
  - o_rready=1.
  - Flush sets drop=1.
  - On i_rvalid with (drop or i_flush this cycle): discard the beat, drop=0, rready=0, go to IDLE.
  - On i_rvalid otherwise: capture o_inst = (i_rresp==2'b00) ? i_rdata : ERR_INST, record err = (i_rresp!=0), go to HOLD.
- HOLD:
  - Buffer full. o_rvalid_rready = !i_ex_stall && !i_flush (combinational from state). o_bus_err = o_rvalid_rready && err.
  - On the pulse: go to IDLE. The IF stage increments its PC on the same edge, so the next IDLE samples PC+4.
  - On i_flush: discard the buffer, go to IDLE.
  - On stall: hold, with o_inst stable.
- Latency with zero-wait slave, no stall: IDLE→ADDR→DATA→HOLD (pulse)→IDLE, i.e. 4 cycles per instruction; the first pulse arrives 3 cycles after the first IDLE cycle.
- Simultaneous flush and stall: flush wins.
- o_rvalid_rready never asserts in IDLE/ADDR/DATA, and never for a dropped beat.
- A flush in IDLE/ADDR/DATA never produces a pulse for the pre-flush address.
- PC bits [1:0] are ignored, so no misaligned AXI address is ever issued.

Test Plan:
- Reset, then i_pc=0, slave with zero wait and OKAY, rdata=32'h00500093 → AR at addr 0x0. o_rvalid_rready pulses with o_inst=0x00500093. The next AR is at 0x4 (bench models the IF stage's PC+4).
- i_arready held low for 5 cycles with a flush in cycle 2 → o_araddr/o_arvalid stay stable until the handshake. The beat is returned but no pulse occurs; the next AR uses the branch target 0x100.
- Flush on the same cycle as i_rvalid in DATA → beat discarded, no pulse, state IDLE, next AR at the new PC.
- Beat captured, then i_ex_stall high for 3 cycles → no pulse during the stall and o_inst stable. A single pulse occurs on the first unstalled cycle; no duplicate pulse follows.
- i_rresp=2'b10 with rdata=0xDEADBEEF → o_inst=0x00000013, o_bus_err and o_rvalid_rready pulse together.
- rst driven low while in DATA → all outputs go to 0 immediately (async). After release, the first AR is issued from i_pc.
